fpmult_execute_iter: RTL and testbench
======================================

# fpmult_execute_iter

Parametrised, multi-cycle execute stage for the FPMult datapath. Takes unpacked operands (sign, biased exponent, fraction), forms the full hidden-one mantissa product by iterating a narrow SPLIT_W-bit multiplier slice over operand B, then normalises. It emits the product sign, the unbiased-sum exponent, the normalised fraction and the GRS sticky flag to the rounding stage behind a valid/ready handshake. It sits between FPMult's prenormalise and round stages.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, stored fraction width (hidden one excluded)
- SPLIT_W, 17, multiplier slice width on B per pass (1 ≤ SPLIT_W ≤ MAN_W+1)
- Derived: P = ceil((MAN_W+1)/SPLIT_W) passes; PW = 2*(MAN_W+1) product width
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands
- a  in  MAN_W  fraction of A
- b  in  MAN_W  fraction of B
- Ea  in  EXP_W  A exponent
- Eb  in  EXP_W  B exponent
- Sa  in  1  A sign
- Sb  in  1  B sign
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- Sp  out  1  product sign
- NormE  out  EXP_W+1  normalised exponent
- NormM  out  MAN_W  normalised fraction
- GRS  out  1  round/sticky flag
- busy  out  1  high in MUL or NORM

## Operation
- States: IDLE, MUL, NORM, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: latch A'={1,a}, B'={1,b}, Ea, Eb, Sa^Sb; clear accumulator Mp (PW bits) and pass counter k; → MUL.
- MUL: one pass per cycle, k = 0..P-1, LSB slice first: Mp += (A' * B'[k*SPLIT_W +: SPLIT_W]) << (k*SPLIT_W). The last slice is narrower when (MAN_W+1) mod SPLIT_W ≠ 0; missing bits are zero. After pass P-1 → NORM.
- NORM (1 cycle), with ovf = Mp[PW-1]; registers load:
  - NormM = ovf ? Mp[2*MAN_W : MAN_W+1] : Mp[2*MAN_W-1 : MAN_W]
  - NormE = Ea + Eb + ovf, zero-extended to EXP_W+1; no bias subtraction, no saturation.
  - GRS = (Mp[MAN_W] & Mp[MAN_W+1]) | OR(Mp[MAN_W-1:0])
  - Sp = latched sign.
  - → DONE.
- DONE: out_valid=1. Outputs are held stable until out_ready. On out_ready → IDLE.
- No special-case handling (zero/denormal/Inf/NaN). The hidden one is always inserted; exceptions belong to the round stage.
- Arithmetic is unsigned. Accumulator is full PW width and cannot overflow since (2^(MAN_W+1)-1)^2 < 2^PW.

## Timing
- Reset values: in_ready=0 during the rst cycle, then 1. out_valid=0, busy=0, Sp=0, NormE=0, NormM=0, GRS=0. Accumulator and counter are cleared.
- Latency: accept edge → out_valid high after P+1 cycles (default 3).
- Throughput: one operation per P+3 cycles at best; no overlap.
- in_ready is high only in IDLE. It is low in the cycle out_valid is accepted (re-arms the next cycle).
- out_valid low→high only on entering DONE. It never drops without out_ready (or rst).
- in_valid during MUL/NORM/DONE is ignored; operand registers are untouched.
- rst in any state wins over all other inputs: next cycle is IDLE with reset values. An in-flight result is discarded, never emitted.
- out_ready while not in DONE has no effect.

## Test plan
- Defaults, a=0, b=0, Ea=Eb=127, Sa=0, Sb=1 → after 3 cycles: Sp=1, NormE=254, NormM=0, GRS=0.
- a=b=0x400000 (1.5×1.5), Ea=Eb=127 → ovf path: NormE=255, NormM=0x100000, GRS=0.
- a=b=0x7FFFFF, Ea=Eb=255 → Mp=0xFFFFFE000001: NormM=0x7FFFFE, GRS=1, NormE=511 (no wrap in EXP_W+1).
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and changing operands → outputs stable, in_ready=0 throughout. Release → one handshake, then the next op is accepted from IDLE.
- Assert rst for one cycle while in MUL pass 1 → next cycle IDLE, all outputs zero, no out_valid ever for that op. A following op completes correctly.
- Parameters EXP_W=5, MAN_W=10, SPLIT_W=4 (P=3, short last slice): sweep 2000 random operands against a reference model (full product, same normalise/GRS rules). Every result must match, with latency 4 cycles.

Source files
------------

// File: rtl/fpmult_execute_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : fpmult_execute_iter_if
// Description : Operand/result handshake bundle for the FPMult execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpmult_execute_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic               in_valid;
    logic               in_ready;
    logic [MAN_W-1:0]   a;
    logic [MAN_W-1:0]   b;
    logic [EXP_W-1:0]   Ea;
    logic [EXP_W-1:0]   Eb;
    logic               Sa;
    logic               Sb;
    logic               out_valid;
    logic               out_ready;
    logic               Sp;
    logic [EXP_W:0]     NormE;
    logic [MAN_W-1:0]   NormM;
    logic               GRS;
    logic               busy;

    modport master (
        output in_valid, a, b, Ea, Eb, Sa, Sb, out_ready,
        input  in_ready, out_valid, Sp, NormE, NormM, GRS, busy
    );

    modport slave (
        input  in_valid, a, b, Ea, Eb, Sa, Sb, out_ready,
        output in_ready, out_valid, Sp, NormE, NormM, GRS, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpmult_execute_iter.sv
`default_nettype none
// ============================================================================
// Module      : fpmult_execute_iter
// Description : Multi-cycle mantissa multiply (SPLIT_W-bit slices of B) with
//               normalisation, feeding the FPMult round stage.
// Revision    : 1.0 - initial release
// ============================================================================
module fpmult_execute_iter #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int SPLIT_W = 17
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fpmult_execute_iter_if.slave bus
);
    localparam int c_P  = (MAN_W + SPLIT_W) / SPLIT_W;
    localparam int c_PW = 2 * (MAN_W + 1);
    localparam int c_BW = c_P * SPLIT_W;
    localparam int c_KW = (c_P > 1) ? $clog2(c_P) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_NORM = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [MAN_W:0]    r_a;
    logic [c_BW-1:0]   r_b;
    logic [EXP_W-1:0]  r_ea;
    logic [EXP_W-1:0]  r_eb;
    logic              r_sign;
    logic [c_PW-1:0]   r_mp;
    logic [c_KW-1:0]   r_k;
    logic              r_sp;
    logic [EXP_W:0]    r_norm_e;
    logic [MAN_W-1:0]  r_norm_m;
    logic              r_grs;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;

    // B is zero-padded to a whole number of slices, so a short last slice
    // simply multiplies by zeros in its upper bits.
    logic [31:0]       w_shamt;
    logic [c_BW-1:0]   w_b_shift;
    logic [SPLIT_W-1:0] w_slice;
    logic [c_PW-1:0]   w_pp;
    logic [c_PW-1:0]   w_term;
    logic              w_ovf;

    assign w_shamt   = 32'(r_k) * 32'(SPLIT_W);
    assign w_b_shift = r_b >> w_shamt;
    assign w_slice   = w_b_shift[SPLIT_W-1:0];
    assign w_pp      = c_PW'(r_a) * c_PW'(w_slice);
    assign w_term    = w_pp << w_shamt;
    assign w_ovf     = r_mp[c_PW-1];

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.in_valid) w_next = c_MUL;
            c_MUL:   if (r_k == c_KW'(c_P - 1)) w_next = c_NORM;
            c_NORM:  w_next = c_DONE;
            c_DONE:  if (bus.out_ready) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == c_IDLE) && !rst;
        w_out_valid = (r_state == c_DONE);
        w_busy      = (r_state == c_MUL) || (r_state == c_NORM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_sign   <= 1'b0;
            r_mp     <= '0;
            r_k      <= '0;
            r_sp     <= 1'b0;
            r_norm_e <= '0;
            r_norm_m <= '0;
            r_grs    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_a    <= {1'b1, bus.a};
                        r_b    <= c_BW'({1'b1, bus.b});
                        r_ea   <= bus.Ea;
                        r_eb   <= bus.Eb;
                        r_sign <= bus.Sa ^ bus.Sb;
                        r_mp   <= '0;
                        r_k    <= '0;
                    end
                end
                c_MUL: begin
                    r_mp <= r_mp + w_term;
                    r_k  <= r_k + c_KW'(1);
                end
                c_NORM: begin
                    r_sp     <= r_sign;
                    r_norm_e <= {1'b0, r_ea} + {1'b0, r_eb} + {{EXP_W{1'b0}}, w_ovf};
                    r_norm_m <= w_ovf ? r_mp[2*MAN_W:MAN_W+1] : r_mp[2*MAN_W-1:MAN_W];
                    r_grs    <= (r_mp[MAN_W] & r_mp[MAN_W+1]) | (|r_mp[MAN_W-1:0]);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.Sp        = r_sp;
    assign bus.NormE     = r_norm_e;
    assign bus.NormM     = r_norm_m;
    assign bus.GRS       = r_grs;
endmodule
`default_nettype wire

// File: tb/tb_fpmult_execute_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpmult_execute_iter
// Description : Directed and random checks of the execute stage at default and
//               small (5/10/4) parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpmult_execute_iter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fpmult_execute_iter_if #(.EXP_W(8), .MAN_W(23)) bus_d ();
    fpmult_execute_iter_if #(.EXP_W(5), .MAN_W(10)) bus_s ();

    fpmult_execute_iter #(.EXP_W(8), .MAN_W(23), .SPLIT_W(17)) u_dut_d (
        .clk (clk),
        .rst (rst),
        .bus (bus_d.slave)
    );

    fpmult_execute_iter #(.EXP_W(5), .MAN_W(10), .SPLIT_W(4)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on the default instance; 'hold' cycles of backpressure with
    // junk operands on the input side before the result is accepted.
    task automatic run_d(input string tag,
                         input logic [22:0] a, input logic [22:0] b,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic sa, input logic sb, input int hold,
                         input logic e_sp, input logic [8:0] e_ne,
                         input logic [22:0] e_nm, input logic e_grs);
        int w = 0;
        int lat = 0;
        int bad = 0;
        while (!bus_d.in_ready && w < 50) begin step(); w++; end
        check({tag, "_ready"}, bus_d.in_ready, 1'b1);
        bus_d.a = a; bus_d.b = b; bus_d.Ea = ea; bus_d.Eb = eb;
        bus_d.Sa = sa; bus_d.Sb = sb; bus_d.in_valid = 1'b1;
        step();
        bus_d.in_valid = 1'b0;
        while (!bus_d.out_valid && lat < 50) begin step(); lat++; end
        check({tag, "_lat"},   lat, 3);
        check({tag, "_Sp"},    bus_d.Sp, e_sp);
        check({tag, "_NormE"}, bus_d.NormE, e_ne);
        check({tag, "_NormM"}, bus_d.NormM, e_nm);
        check({tag, "_GRS"},   bus_d.GRS, e_grs);
        for (int i = 0; i < hold; i++) begin
            bus_d.in_valid = 1'b1;
            bus_d.a  = 23'($urandom);
            bus_d.b  = 23'($urandom);
            bus_d.Ea = 8'($urandom);
            bus_d.Eb = 8'($urandom);
            step();
            if (bus_d.in_ready !== 1'b0 || bus_d.out_valid !== 1'b1 ||
                bus_d.Sp !== e_sp || bus_d.NormE !== e_ne ||
                bus_d.NormM !== e_nm || bus_d.GRS !== e_grs) bad++;
        end
        if (hold > 0) check({tag, "_hold_stable"}, bad, 0);
        bus_d.in_valid  = 1'b0;
        bus_d.out_ready = 1'b1;
        step();
        bus_d.out_ready = 1'b0;
        check({tag, "_rearm"}, {bus_d.out_valid, bus_d.in_ready}, 2'b01);
    endtask

    task automatic run_s(input logic [9:0] a, input logic [9:0] b,
                         input logic [4:0] ea, input logic [4:0] eb,
                         input logic sa, input logic sb);
        logic [21:0] mp;
        logic        ovf;
        logic [9:0]  e_nm;
        logic [5:0]  e_ne;
        logic        e_grs;
        int w = 0;
        int lat = 0;
        mp    = {1'b1, a} * {1'b1, b};
        ovf   = mp[21];
        e_nm  = ovf ? mp[20:11] : mp[19:10];
        e_ne  = {1'b0, ea} + {1'b0, eb} + {5'd0, ovf};
        e_grs = (mp[10] & mp[11]) | (|mp[9:0]);
        while (!bus_s.in_ready && w < 50) begin step(); w++; end
        bus_s.a = a; bus_s.b = b; bus_s.Ea = ea; bus_s.Eb = eb;
        bus_s.Sa = sa; bus_s.Sb = sb; bus_s.in_valid = 1'b1;
        step();
        bus_s.in_valid = 1'b0;
        while (!bus_s.out_valid && lat < 50) begin step(); lat++; end
        check("s_lat",   lat, 4);
        check("s_Sp",    bus_s.Sp, sa ^ sb);
        check("s_NormE", bus_s.NormE, e_ne);
        check("s_NormM", bus_s.NormM, e_nm);
        check("s_GRS",   bus_s.GRS, e_grs);
        bus_s.out_ready = 1'b1;
        step();
        bus_s.out_ready = 1'b0;
    endtask

    initial begin
        int vcount;
        bus_d.in_valid = 1'b0; bus_d.out_ready = 1'b0;
        bus_d.a = '0; bus_d.b = '0; bus_d.Ea = '0; bus_d.Eb = '0;
        bus_d.Sa = 1'b0; bus_d.Sb = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b0;
        bus_s.a = '0; bus_s.b = '0; bus_s.Ea = '0; bus_s.Eb = '0;
        bus_s.Sa = 1'b0; bus_s.Sb = 1'b0;
        rst = 1'b1;
        step();
        check("rst_in_ready", bus_d.in_ready, 1'b0);
        check("rst_outs", {bus_d.out_valid, bus_d.busy, bus_d.Sp, bus_d.NormE,
                           bus_d.NormM, bus_d.GRS}, '0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus_d.in_ready, 1'b1);

        run_d("one_x_one", 23'h0, 23'h0, 8'd127, 8'd127, 1'b0, 1'b1, 0,
              1'b1, 9'd254, 23'h0, 1'b0);
        run_d("ovf", 23'h400000, 23'h400000, 8'd127, 8'd127, 1'b0, 1'b0, 0,
              1'b0, 9'd255, 23'h100000, 1'b0);
        run_d("max", 23'h7FFFFF, 23'h7FFFFF, 8'd255, 8'd255, 1'b0, 1'b0, 0,
              1'b0, 9'd511, 23'h7FFFFE, 1'b1);
        run_d("bp", 23'h400000, 23'h0, 8'd100, 8'd20, 1'b1, 1'b1, 10,
              1'b0, 9'd120, 23'h400000, 1'b0);
        run_d("after_bp", 23'h0, 23'h0, 8'd1, 8'd2, 1'b1, 1'b0, 0,
              1'b1, 9'd3, 23'h0, 1'b0);

        // Abort an op in its second multiply pass.
        bus_d.a = 23'h123456; bus_d.b = 23'h654321; bus_d.Ea = 8'd9; bus_d.Eb = 8'd9;
        bus_d.in_valid = 1'b1;
        step();
        bus_d.in_valid = 1'b0;
        check("mid_busy", bus_d.busy, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_idle", {bus_d.in_ready, bus_d.out_valid, bus_d.busy}, 3'b100);
        check("abort_outs", {bus_d.Sp, bus_d.NormE, bus_d.NormM, bus_d.GRS}, '0);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_d.out_valid) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        run_d("after_abort", 23'h000001, 23'h000001, 8'd3, 8'd4, 1'b1, 1'b0, 0,
              1'b1, 9'd7, 23'h000002, 1'b1);

        run_s(10'h000, 10'h000, 5'd15, 5'd15, 1'b0, 1'b1);
        run_s(10'h3FF, 10'h3FF, 5'd31, 5'd31, 1'b1, 1'b1);
        for (int i = 0; i < 2000; i++)
            run_s(10'($urandom), 10'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
